// File: rtl/bin_to_bcd3.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
// Produces units/tens/hundreds digits held stable between conversions for a display mux.
module bin_to_bcd3 #(
    parameter int WIDTH = 10,
    parameter bit AUTO  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       bcd0,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [1:0]       state
);

    // Handshake: a request (start, or an input change when AUTO) is accepted only
    // in IDLE; each accepted request yields exactly one done pulse, never queued.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           cur;
    state_t           nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] last;
    logic [3:0]       d0;
    logic [3:0]       d1;
    logic [3:0]       d2;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;

    logic             launch;
    logic             last_shift;
    logic             in_over;
    logic [3:0]       a0;
    logic [3:0]       a1;
    logic [3:0]       a2;
    logic [3:0]       s0;
    logic [3:0]       s1;
    logic [3:0]       s2;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_comb begin
        launch     = 1'b0;
        last_shift = 1'b0;
        in_over    = 1'b0;
        a0         = add3(d0);
        a1         = add3(d1);
        a2         = add3(d2);
        // Shift {d2, d1, d0, sr} left by one after the per-digit adjust.
        s0         = {a0[2:0], sr[WIDTH-1]};
        s1         = {a1[2:0], a0[3]};
        s2         = {a2[2:0], a1[3]};
        if (cur == IDLE) begin
            launch = start || (AUTO && (bin_in != last));
        end
        if ((cur == SHIFT) && (cnt == CW'(1))) begin
            last_shift = 1'b1;
        end
        in_over = ({{(32 - WIDTH){1'b0}}, bin_in} > 32'd999);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt  = cur;
        busy = 1'b0;
        done = 1'b0;
        case (cur)
            IDLE: begin
                if (launch) begin
                    nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    assign state = cur;

    // Scratch datapath: shift register, digits, counter, pending overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            last     <= '0;
            d0       <= 4'd0;
            d1       <= 4'd0;
            d2       <= 4'd0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else if (launch) begin
            sr       <= bin_in;
            last     <= bin_in;
            d0       <= 4'd0;
            d1       <= 4'd0;
            d2       <= 4'd0;
            cnt      <= CW'(WIDTH);
            ovf_pend <= in_over;
        end else if (cur == SHIFT) begin
            sr  <= {sr[WIDTH-2:0], 1'b0};
            d0  <= s0;
            d1  <= s1;
            d2  <= s2;
            cnt <= cnt - CW'(1);
        end
    end

    // Visible digits load only on entry to DONE, from the final shift's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd0 <= 4'd0;
            bcd1 <= 4'd0;
            bcd2 <= 4'd0;
            ovf  <= 1'b0;
        end else if (last_shift) begin
            if (ovf_pend) begin
                bcd0 <= 4'd9;
                bcd1 <= 4'd9;
                bcd2 <= 4'd9;
                ovf  <= 1'b1;
            end else begin
                bcd0 <= s0;
                bcd1 <= s1;
                bcd2 <= s2;
                ovf  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd3.sv
// Bench for bin_to_bcd3: one AUTO=0 and one AUTO=1 instance, scoreboarded
// against hand-computed {ovf, hundreds, tens, units} values.
module tb_bin_to_bcd3;
    localparam int W = 10;
    localparam int T = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_m, start_a;
    logic [W-1:0] bin_m, bin_a;
    logic         busy_m, done_m, ovf_m, busy_a, done_a, ovf_a;
    logic [3:0]   bcd0_m, bcd1_m, bcd2_m, bcd0_a, bcd1_a, bcd2_a;
    logic [1:0]   state_m, state_a;

    int n_checks = 0;
    int n_errors = 0;
    int busy_run_m = 0;
    int busy_run_a = 0;

    logic [12:0] exp_q_m[$];
    logic [12:0] exp_q_a[$];
    time         t_q_m[$];
    time         t_q_a[$];

    // ---------------- clock / reset ----------------
    always #(T / 2) clk = ~clk;

    bin_to_bcd3 #(.WIDTH(W), .AUTO(1'b0)) u_man (
        .clk(clk), .rst_n(rst_n), .start(start_m), .bin_in(bin_m),
        .busy(busy_m), .done(done_m), .ovf(ovf_m),
        .bcd0(bcd0_m), .bcd1(bcd1_m), .bcd2(bcd2_m), .state(state_m)
    );

    bin_to_bcd3 #(.WIDTH(W), .AUTO(1'b1)) u_auto (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a),
        .bcd0(bcd0_a), .bcd1(bcd1_a), .bcd2(bcd2_a), .state(state_a)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run_m = 0;
        end else begin
            if (busy_m) busy_run_m++;
            if (done_m) begin
                if (exp_q_m.size() == 0) begin
                    flag("unexpected done (manual)");
                end else begin
                    logic [12:0] e;
                    time         t0;
                    e  = exp_q_m.pop_front();
                    t0 = t_q_m.pop_front();
                    check("digits manual", {19'd0, ovf_m, bcd2_m, bcd1_m, bcd0_m}, {19'd0, e});
                    check("latency manual", 32'(($time - t0 + T / 2) / T), 32'(W + 1));
                    check("busy cycles manual", 32'(busy_run_m), 32'(W));
                end
                busy_run_m = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run_a = 0;
        end else begin
            if (busy_a) busy_run_a++;
            if (done_a) begin
                if (exp_q_a.size() == 0) begin
                    flag("unexpected done (auto)");
                end else begin
                    logic [12:0] e;
                    time         t0;
                    e  = exp_q_a.pop_front();
                    t0 = t_q_a.pop_front();
                    check("digits auto", {19'd0, ovf_a, bcd2_a, bcd1_a, bcd0_a}, {19'd0, e});
                    check("latency auto", 32'(($time - t0 + T / 2) / T), 32'(W + 1));
                    check("busy cycles auto", 32'(busy_run_a), 32'(W));
                end
                busy_run_a = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_m(input logic [W-1:0] v, input logic [12:0] e);
        @(negedge clk);
        bin_m   = v;
        start_m = 1'b1;
        exp_q_m.push_back(e);
        t_q_m.push_back($time + T / 2);
        @(negedge clk);
        start_m = 1'b0;
    endtask

    task automatic change_a(input logic [W-1:0] v, input logic with_start, input logic [12:0] e);
        @(negedge clk);
        bin_a   = v;
        start_a = with_start;
        exp_q_a.push_back(e);
        t_q_a.push_back($time + T / 2);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic drain(input bit auto_side);
        for (int i = 0; i < 40; i++) begin
            if ((auto_side ? exp_q_a.size() : exp_q_m.size()) == 0) break;
            @(negedge clk);
        end
        if (!auto_side && exp_q_m.size() != 0) begin
            flag("timeout waiting for done (manual)");
            exp_q_m.delete();
            t_q_m.delete();
        end
        if (auto_side && exp_q_a.size() != 0) begin
            flag("timeout waiting for done (auto)");
            exp_q_a.delete();
            t_q_a.delete();
        end
    endtask

    logic [W-1:0] sweep_in[6]  = '{10'd0, 10'd9, 10'd10, 10'd99, 10'd100, 10'd999};
    logic [12:0]  sweep_exp[6] = '{13'h0000, 13'h0009, 13'h0010, 13'h0099, 13'h0100, 13'h0999};

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        start_m = 1'b0;
        start_a = 1'b0;
        bin_m   = '0;
        bin_a   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything stays at zero.
        for (int k = 0; k < 4; k++) begin
            repeat (5) @(negedge clk);
            check("idle outputs", {25'd0, busy_m, done_m, ovf_m, bcd2_m, bcd1_m, bcd0_m}, 32'd0);
        end
        check("idle state", {30'd0, state_m}, 32'd0);

        // Basic conversion with timing.
        issue_m(10'd255, 13'h0255);
        drain(1'b0);

        for (int k = 0; k < 6; k++) begin
            issue_m(sweep_in[k], sweep_exp[k]);
            drain(1'b0);
        end

        // Overflow substitution and recovery.
        issue_m(10'd1000, 13'h1999);
        drain(1'b0);
        issue_m(10'd1023, 13'h1999);
        drain(1'b0);
        issue_m(10'd5, 13'h0005);
        drain(1'b0);

        // Re-pulse during SHIFT is ignored; outputs hold the previous result.
        issue_m(10'd123, 13'h0123);
        check("hold during shift", {19'd0, ovf_m, bcd2_m, bcd1_m, bcd0_m}, 32'h0005);
        @(negedge clk);
        @(negedge clk);
        bin_m   = 10'd456;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        check("hold after ignored start", {19'd0, ovf_m, bcd2_m, bcd1_m, bcd0_m}, 32'h0005);
        drain(1'b0);
        repeat (20) @(negedge clk);
        check("state idle after ignored start", {30'd0, state_m}, 32'd0);

        // Reset mid-conversion: abort, no done pulse.
        @(negedge clk);
        bin_m   = 10'd777;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before abort", {31'd0, busy_m}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("outputs in reset", {25'd0, busy_m, done_m, ovf_m, bcd2_m, bcd1_m, bcd0_m}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("outputs after abort", {25'd0, busy_m, done_m, ovf_m, bcd2_m, bcd1_m, bcd0_m}, 32'd0);

        // AUTO instance: self-start on input change only.
        change_a(10'd42, 1'b0, 13'h0042);
        drain(1'b1);
        change_a(10'd43, 1'b0, 13'h0043);
        drain(1'b1);
        repeat (30) @(negedge clk);
        check("auto holds when unchanged", {27'd0, busy_a, bcd2_a[3:0]}, 32'd0);
        check("auto digits held", {19'd0, ovf_a, bcd2_a, bcd1_a, bcd0_a}, 32'h0043);
        change_a(10'd44, 1'b1, 13'h0044);
        drain(1'b1);
        repeat (30) @(negedge clk);
        check("auto state idle", {30'd0, state_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(T * 20000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
